core_wb_arb: RTL and testbench

Write-back port arbiter and long-latency scoreboard for the core's single register-file write port. It grants that port each cycle to one of two requesters: the in-order pipeline write-back stage or the long-latency unit (multi-cycle mul/div, slow loads). A starvation counter guarantees forward progress for the long-latency unit. A pending-destination bitmap tells the hazard logic which registers still await a long-latency result.

---
 rtl/core_wb_arb.sv | 110 +++++++++++
 tb/tb_core_wb_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_arb.sv
// core_wb_arb: grants the single register-file write port to either the pipeline
// write-back stage or the long-latency unit, and tracks long-latency destinations.
module core_wb_arb #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned STARVE_LIM  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_vld_i,
  input  logic [RFIDX_WIDTH-1:0]    pipe_rd_idx_i,
  input  logic [XLEN-1:0]           pipe_rd_data_i,
  output logic                      pipe_rdy_o,
  input  logic                      lu_vld_i,
  input  logic [RFIDX_WIDTH-1:0]    lu_rd_idx_i,
  input  logic [XLEN-1:0]           lu_rd_data_i,
  output logic                      lu_rdy_o,
  input  logic                      lu_issue_i,
  input  logic [RFIDX_WIDTH-1:0]    lu_issue_idx_i,
  output logic                      rf_wen_o,
  output logic [RFIDX_WIDTH-1:0]    rf_widx_o,
  output logic [XLEN-1:0]           rf_wdata_o,
  output logic [2**RFIDX_WIDTH-1:0] rd_pending_o
);

  localparam int unsigned NREG           = 2**RFIDX_WIDTH;
  localparam logic [3:0]  STARVE_CNT_LIM = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LU
  } gnt_e;

  gnt_e            gnt;
  logic            pipe_real;
  logic            lu_real;
  logic            force_lu;
  logic [3:0]      starve_cnt;
  logic [3:0]      starve_nxt;
  logic [NREG-1:0] issue_set;
  logic [NREG-1:0] lu_clr;
  logic [NREG-1:0] pend_nxt;

  // Writes to x0 are "real" for nobody: they are acknowledged and dropped.
  always_comb begin
    pipe_real = pipe_vld_i && (pipe_rd_idx_i != '0);
    lu_real   = lu_vld_i && (lu_rd_idx_i != '0);
    force_lu  = (starve_cnt == STARVE_CNT_LIM);
    gnt       = GNT_NONE;
    if (lu_real && (!pipe_real || force_lu)) begin
      gnt = GNT_LU;
    end else if (pipe_real) begin
      gnt = GNT_PIPE;
    end
  end

  assign pipe_rdy_o = !pipe_real || (gnt == GNT_PIPE);
  assign lu_rdy_o   = !lu_real || (gnt == GNT_LU);

  always_comb begin
    starve_nxt = '0;
    if (lu_real && (gnt != GNT_LU)) begin
      starve_nxt = force_lu ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  // A fresh issue to the index being retired wins: the new op is now outstanding.
  always_comb begin
    issue_set = '0;
    lu_clr    = '0;
    if (lu_issue_i && (lu_issue_idx_i != '0)) begin
      issue_set[lu_issue_idx_i] = 1'b1;
    end
    if (gnt == GNT_LU) begin
      lu_clr[lu_rd_idx_i] = 1'b1;
    end
    pend_nxt    = (rd_pending_o & ~lu_clr) | issue_set;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      rd_pending_o <= '0;
      rf_wen_o     <= 1'b0;
      rf_widx_o    <= '0;
      rf_wdata_o   <= '0;
    end else begin
      starve_cnt   <= starve_nxt;
      rd_pending_o <= pend_nxt;
      rf_wen_o     <= (gnt != GNT_NONE);
      case (gnt)
        GNT_PIPE: begin
          rf_widx_o  <= pipe_rd_idx_i;
          rf_wdata_o <= pipe_rd_data_i;
        end
        GNT_LU: begin
          rf_widx_o  <= lu_rd_idx_i;
          rf_wdata_o <= lu_rd_data_i;
        end
        default: begin
          rf_widx_o  <= rf_widx_o;
          rf_wdata_o <= rf_wdata_o;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_arb.sv
// Self-checking bench for core_wb_arb: directed scenarios plus a randomized
// handshake run compared against a rule-level reference model.
module tb_core_wb_arb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned LIM  = 4;

  logic            clk;
  logic            rst_n;
  logic            pipe_vld_i;
  logic [RW-1:0]   pipe_rd_idx_i;
  logic [XLEN-1:0] pipe_rd_data_i;
  logic            pipe_rdy_o;
  logic            lu_vld_i;
  logic [RW-1:0]   lu_rd_idx_i;
  logic [XLEN-1:0] lu_rd_data_i;
  logic            lu_rdy_o;
  logic            lu_issue_i;
  logic [RW-1:0]   lu_issue_idx_i;
  logic            rf_wen_o;
  logic [RW-1:0]   rf_widx_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic [31:0]     rd_pending_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_cnt;
  bit              m_pend[32];
  logic            m_wen;
  logic [RW-1:0]   m_widx;
  logic [XLEN-1:0] m_wdata;

  core_wb_arb #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_vld_i(pipe_vld_i), .pipe_rd_idx_i(pipe_rd_idx_i),
    .pipe_rd_data_i(pipe_rd_data_i), .pipe_rdy_o(pipe_rdy_o),
    .lu_vld_i(lu_vld_i), .lu_rd_idx_i(lu_rd_idx_i),
    .lu_rd_data_i(lu_rd_data_i), .lu_rdy_o(lu_rdy_o),
    .lu_issue_i(lu_issue_i), .lu_issue_idx_i(lu_issue_idx_i),
    .rf_wen_o(rf_wen_o), .rf_widx_o(rf_widx_o), .rf_wdata_o(rf_wdata_o),
    .rd_pending_o(rd_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Who wins this cycle, decided from the rules on the current inputs.
  task automatic model_grant(output bit pw, output bit lw, output bit prdy, output bit lrdy);
    bit pr, lr;
    pr = pipe_vld_i && (pipe_rd_idx_i != 0);
    lr = lu_vld_i && (lu_rd_idx_i != 0);
    pw = 0;
    lw = 0;
    if (pr && lr) begin
      if (m_cnt == LIM) lw = 1; else pw = 1;
    end else if (pr) begin
      pw = 1;
    end else if (lr) begin
      lw = 1;
    end
    prdy = pr ? pw : 1'b1;
    lrdy = lr ? lw : 1'b1;
  endtask

  task automatic model_edge();
    bit pw, lw, prdy, lrdy, lr;
    model_grant(pw, lw, prdy, lrdy);
    lr = lu_vld_i && (lu_rd_idx_i != 0);
    m_wen = pw || lw;
    if (pw) begin m_widx = pipe_rd_idx_i; m_wdata = pipe_rd_data_i; end
    if (lw) begin m_widx = lu_rd_idx_i;   m_wdata = lu_rd_data_i;   end
    if (lw || !lr) m_cnt = 0;
    else if (m_cnt < LIM) m_cnt = m_cnt + 1;
    if (lw) m_pend[lu_rd_idx_i] = 0;
    if (lu_issue_i && (lu_issue_idx_i != 0)) m_pend[lu_issue_idx_i] = 1;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_wen = 0;
    m_widx = '0;
    m_wdata = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  task automatic idle_inputs();
    pipe_vld_i = 0; pipe_rd_idx_i = '0; pipe_rd_data_i = '0;
    lu_vld_i = 0; lu_rd_idx_i = '0; lu_rd_data_i = '0;
    lu_issue_i = 0; lu_issue_idx_i = '0;
  endtask

  // Advance one clock edge with the model; returns #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (rf_wen_o !== 1'b0) begin errors++; $display("FAIL reset_wen got=%0b exp=0", rf_wen_o); end
    checks++; if (rf_widx_o !== '0) begin errors++; $display("FAIL reset_widx got=%0d exp=0", rf_widx_o); end
    checks++; if (rf_wdata_o !== '0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata_o); end
    checks++; if (rd_pending_o !== 32'h0) begin errors++; $display("FAIL reset_pending got=%h exp=0", rd_pending_o); end
    checks++; if (pipe_rdy_o !== 1'b1 || lu_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%0b%0b exp=11", pipe_rdy_o, lu_rdy_o); end
  endtask

  task automatic test_pipe_only();
    pipe_vld_i = 1; pipe_rd_idx_i = 5; pipe_rd_data_i = 32'hDEAD_BEEF;
    #2;
    checks++; if (pipe_rdy_o !== 1'b1) begin errors++; $display("FAIL pipe_only_rdy got=%0b exp=1", pipe_rdy_o); end
    step();
    idle_inputs();
    checks++; if (rf_wen_o !== 1'b1 || rf_widx_o !== 5 || rf_wdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL pipe_only_write got=%0b/%0d/%h exp=1/5/deadbeef", rf_wen_o, rf_widx_o, rf_wdata_o); end
    step();
    checks++; if (rf_wen_o !== 1'b0 || rf_widx_o !== 5) begin
      errors++; $display("FAIL pipe_only_idle got=%0b/%0d exp=0/5", rf_wen_o, rf_widx_o); end
  endtask

  // Continuous pipe traffic against a held lu x7; lu wins in cycle LIM.
  task automatic run_conflict(input string tag);
    bit p_acc;
    p_acc = 1;
    lu_vld_i = 1; lu_rd_idx_i = 7; lu_rd_data_i = 32'h1234;
    for (int c = 0; c <= int'(LIM); c++) begin
      if (p_acc) begin
        pipe_vld_i = 1; pipe_rd_idx_i = RW'(10 + c); pipe_rd_data_i = $urandom;
      end
      #2;
      checks++;
      if (lu_rdy_o !== (c == int'(LIM)) || pipe_rdy_o !== (c != int'(LIM))) begin
        errors++; $display("FAIL %s_rdy c=%0d got=p%0b/l%0b exp=p%0b/l%0b", tag, c,
                           pipe_rdy_o, lu_rdy_o, c != int'(LIM), c == int'(LIM)); end
      p_acc = pipe_rdy_o;
      step();
      if (c == int'(LIM)) begin
        lu_vld_i = 0;
        checks++; if (rf_wen_o !== 1'b1 || rf_widx_o !== 7 || rf_wdata_o !== 32'h1234) begin
          errors++; $display("FAIL %s_lu_write got=%0b/%0d/%h exp=1/7/1234", tag, rf_wen_o, rf_widx_o, rf_wdata_o); end
      end else begin
        checks++; if (rf_wen_o !== 1'b1 || rf_widx_o !== RW'(10 + c)) begin
          errors++; $display("FAIL %s_pipe_write c=%0d got=%0b/%0d exp=1/%0d", tag, c, rf_wen_o, rf_widx_o, 10 + c); end
      end
    end
  endtask

  task automatic test_conflict();
    run_conflict("conflict");
    // Stalled pipe write goes through, then a fresh lu request must lose again.
    #2; step();
    lu_vld_i = 1; lu_rd_idx_i = 7; lu_rd_data_i = 32'h55;
    pipe_rd_idx_i = 20; pipe_rd_data_i = $urandom;
    #2;
    checks++; if (lu_rdy_o !== 1'b0) begin errors++; $display("FAIL conflict_cnt_cleared got=%0b exp=0", lu_rdy_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_x0();
    pipe_vld_i = 1; pipe_rd_idx_i = 0; pipe_rd_data_i = 32'hAAAA;
    lu_vld_i = 1; lu_rd_idx_i = 9; lu_rd_data_i = 32'h9999;
    #2;
    checks++; if (pipe_rdy_o !== 1'b1 || lu_rdy_o !== 1'b1) begin
      errors++; $display("FAIL x0_rdy got=%0b%0b exp=11", pipe_rdy_o, lu_rdy_o); end
    step();
    idle_inputs();
    checks++; if (rf_wen_o !== 1'b1 || rf_widx_o !== 9 || rf_wdata_o !== 32'h9999) begin
      errors++; $display("FAIL x0_write got=%0b/%0d/%h exp=1/9/9999", rf_wen_o, rf_widx_o, rf_wdata_o); end
    lu_issue_i = 1; lu_issue_idx_i = 0;
    step();
    checks++; if (rf_wen_o !== 1'b0) begin errors++; $display("FAIL x0_single_write got=%0b exp=0", rf_wen_o); end
    checks++; if (rd_pending_o[0] !== 1'b0) begin errors++; $display("FAIL x0_issue_bit0 got=%0b exp=0", rd_pending_o[0]); end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    lu_issue_i = 1; lu_issue_idx_i = 3;
    step();
    idle_inputs();
    checks++; if (rd_pending_o !== 32'h8) begin errors++; $display("FAIL sb_set got=%h exp=00000008", rd_pending_o); end
    lu_vld_i = 1; lu_rd_idx_i = 3; lu_rd_data_i = 32'h33;
    step();
    idle_inputs();
    checks++; if (rd_pending_o[3] !== 1'b0) begin errors++; $display("FAIL sb_clear got=%0b exp=0", rd_pending_o[3]); end
    lu_issue_i = 1; lu_issue_idx_i = 3;
    step();
    lu_vld_i = 1; lu_rd_idx_i = 3; lu_rd_data_i = 32'h34;
    step();
    idle_inputs();
    checks++; if (rd_pending_o[3] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%0b exp=1", rd_pending_o[3]); end
    lu_issue_i = 1; lu_issue_idx_i = 3;
    step();
    idle_inputs();
    checks++; if (rd_pending_o !== 32'h8) begin errors++; $display("FAIL sb_reissue got=%h exp=00000008", rd_pending_o); end
  endtask

  task automatic test_random();
    bit pw, lw, prdy, lrdy;
    bit p_acc, l_acc;
    p_acc = 1; l_acc = 1;
    for (int n = 0; n < 1500; n++) begin
      if (!pipe_vld_i || p_acc) begin
        pipe_vld_i = ($urandom % 4) != 0; pipe_rd_idx_i = RW'($urandom % 8); pipe_rd_data_i = $urandom;
      end
      if (!lu_vld_i || l_acc) begin
        lu_vld_i = ($urandom % 2) != 0; lu_rd_idx_i = RW'($urandom % 8); lu_rd_data_i = $urandom;
      end
      lu_issue_i = ($urandom % 3) == 0; lu_issue_idx_i = RW'($urandom % 8);
      #2;
      model_grant(pw, lw, prdy, lrdy);
      checks++; if (pipe_rdy_o !== prdy || lu_rdy_o !== lrdy) begin
        errors++; $display("FAIL rand_rdy n=%0d got=p%0b/l%0b exp=p%0b/l%0b", n, pipe_rdy_o, lu_rdy_o, prdy, lrdy); end
      p_acc = prdy; l_acc = lrdy;
      step();
      checks++; if (rf_wen_o !== m_wen || rf_widx_o !== m_widx || rf_wdata_o !== m_wdata) begin
        errors++; $display("FAIL rand_wport n=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", n,
                           rf_wen_o, rf_widx_o, rf_wdata_o, m_wen, m_widx, m_wdata); end
      checks++; if (rd_pending_o !== pend_vec()) begin
        errors++; $display("FAIL rand_pending n=%0d got=%h exp=%h", n, rd_pending_o, pend_vec()); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    lu_issue_i = 1; lu_issue_idx_i = 3; step();
    lu_issue_idx_i = 12; step();
    lu_issue_i = 0;
    lu_vld_i = 1; lu_rd_idx_i = 7; lu_rd_data_i = 32'h77;
    for (int c = 0; c < 3; c++) begin
      pipe_vld_i = 1; pipe_rd_idx_i = RW'(20 + c); pipe_rd_data_i = $urandom;
      step();
    end
    checks++; if (rd_pending_o !== 32'h1008 || rf_wen_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre got=%h/%0b exp=00001008/1", rd_pending_o, rf_wen_o); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (rf_wen_o !== 1'b0 || rf_widx_o !== '0 || rf_wdata_o !== '0 || rd_pending_o !== 32'h0) begin
      errors++; $display("FAIL mid_async_clear got=%0b/%0d/%h/%h exp=0/0/0/0", rf_wen_o, rf_widx_o, rf_wdata_o, rd_pending_o); end
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
    run_conflict("post_reset");
    idle_inputs();
    step();
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    model_clear();
    test_reset();
    test_pipe_only();
    test_conflict();
    test_x0();
    test_scoreboard();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
